// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs mnemonic requests into 32-bit MIPS words
// and streams them into instruction memory at consecutive addresses.
// Ports: in_* request handshake/fields, flush restarts at address 0,
// imem_* write port (held until imem_ready), words_written/err_illegal/
// full status. Optional MIPS_ENC_DELAY_SLOT_PAD_EN appends a nop after
// every beq/j/jal/jr.
module mips_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   words_written,
  output logic              err_illegal,
  output logic              full
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  logic [1:0] state;

  logic isAdd, isAnd, isNor, isJr;
  logic isSlt, isAddi, isAndi, isLw;
  logic isSw, isBeq, isJal, isJ;

  assign isAdd  = in_op == 4'd0;
  assign isAnd  = in_op == 4'd1;
  assign isNor  = in_op == 4'd2;
  assign isJr   = in_op == 4'd3;
  assign isSlt  = in_op == 4'd4;
  assign isAddi = in_op == 4'd5;
  assign isAndi = in_op == 4'd6;
  assign isLw   = in_op == 4'd7;
  assign isSw   = in_op == 4'd8;
  assign isBeq  = in_op == 4'd9;
  assign isJal  = in_op == 4'd10;
  assign isJ    = in_op == 4'd11;

  logic [31:0] encWord;
  logic        encLegal;

  // Only the fields the format uses are packed; the rest are dropped.
  always_comb begin
    encWord  = '0;
    encLegal = 1'b1;
    unique case (1'b1)
      isAdd:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      isAnd:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
      isNor:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h27};
      isSlt:  encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
      isJr:   encWord = {6'h00, in_rs, 15'h0000, 6'h08};
      isAddi: encWord = {6'h08, in_rs, in_rt, in_imm};
      isAndi: encWord = {6'h0C, in_rs, in_rt, in_imm};
      isLw:   encWord = {6'h23, in_rs, in_rt, in_imm};
      isSw:   encWord = {6'h2B, in_rs, in_rt, in_imm};
      isBeq:  encWord = {6'h04, in_rs, in_rt, in_imm};
      isJal:  encWord = {6'h03, in_target};
      isJ:    encWord = {6'h02, in_target};
      default: encLegal = 1'b0;
    endcase
  end

  logic atLast;
  logic padNext;

  assign atLast = imem_addr == {ADDR_W{1'b1}};

`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
  logic encBranch;
  logic branchReg;

  assign encBranch = isBeq | isJ | isJal | isJr;
  // A branch in the last slot has no room for its delay slot.
  assign padNext   = branchReg & ~atLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchReg <= 1'b0;
    end else if (flush) begin
      branchReg <= 1'b0;
    end else if (state == IDLE && in_valid && encLegal) begin
      branchReg <= encBranch;
    end
  end
`else
  assign padNext = 1'b0;
`endif

  assign in_ready = state == IDLE;
  assign imem_we  = (state == WRITE) || (state == PAD);
  assign full     = state == FULL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (encLegal) begin
              imem_wdata <= encWord;
              state      <= WRITE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (imem_ready) begin
            words_written <= words_written + CNT_ONE;
            if (padNext) begin
              imem_addr  <= imem_addr + ADDR_ONE;
              imem_wdata <= '0;
              state      <= PAD;
            end else if (atLast) begin
              state <= FULL;
            end else begin
              imem_addr <= imem_addr + ADDR_ONE;
              state     <= IDLE;
            end
          end
        end
`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
        PAD: begin
          if (imem_ready) begin
            words_written <= words_written + CNT_ONE;
            if (atLast) begin
              state <= FULL;
            end else begin
              imem_addr <= imem_addr + ADDR_ONE;
              state     <= IDLE;
            end
          end
        end
`endif
        FULL: begin
          state <= FULL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed plus random requests checked
// against a queue-based model of the expected instruction stream.
module tb_mips_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          flush;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready;
  logic [AW:0]   words_written;
  logic          err_illegal;
  logic          full;

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .in_rd(in_rd),
    .in_imm(in_imm),
    .in_target(in_target),
    .flush(flush),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .imem_ready(imem_ready),
    .words_written(words_written),
    .err_illegal(err_illegal),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: words still owed to memory, next address, counters.
  logic [31:0] mQ[$];
  int          mAddr;
  int          mCount;
  bit          mErr;
  bit          mFull;

  logic        obsWe;
  logic        obsReady;
  logic        obsFull;
  logic        obsErr;
  logic [AW-1:0] obsAddr;
  logic [31:0] obsData;
  logic [AW:0] obsWords;

  function automatic logic [31:0] expWord(int unsigned op,
      int unsigned rs, int unsigned rt, int unsigned rd,
      int unsigned imm, int unsigned tgt);
    int unsigned rFunct[5] = '{32, 36, 39, 8, 42};
    int unsigned iOpc[5]   = '{8, 12, 35, 43, 4};
    int unsigned w;
    if (op == 3)
      w = rs * 2097152 + 8;
    else if (op <= 4)
      w = rs * 2097152 + rt * 65536 + rd * 2048 + rFunct[op];
    else if (op <= 9)
      w = iOpc[op-5] * 67108864 + rs * 2097152 + rt * 65536 + imm;
    else if (op == 10)
      w = 3 * 67108864 + tgt;
    else
      w = 2 * 67108864 + tgt;
    return w;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mAddr  = 0;
    mCount = 0;
    mErr   = 0;
    mFull  = 0;
  endtask

  task automatic step(input bit v, input logic [3:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [15:0] imm, input logic [25:0] tgt,
      input bit rdy, input bit fl);
    bit expReady;
    @(negedge clk);
    in_valid   = v;
    in_op      = op;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_imm     = imm;
    in_target  = tgt;
    imem_ready = rdy;
    flush      = fl;
    #1;
    obsWe    = imem_we;
    obsReady = in_ready;
    obsFull  = full;
    obsErr   = err_illegal;
    obsAddr  = imem_addr;
    obsData  = imem_wdata;
    obsWords = words_written;
    expReady = (mQ.size() == 0) && !mFull;
    chk("in_ready", 32'(in_ready), 32'(expReady));
    chk("imem_we", 32'(imem_we), 32'(mQ.size() != 0));
    chk("full", 32'(full), 32'(mFull));
    chk("words", 32'(words_written), 32'(mCount));
    chk("err", 32'(err_illegal), 32'(mErr));
    if (mQ.size() != 0) begin
      chk("addr", 32'(imem_addr), 32'(mAddr));
      chk("wdata", imem_wdata, mQ[0]);
    end
    if (fl) begin
      modelReset();
    end else if (mQ.size() != 0) begin
      if (rdy) begin
        void'(mQ.pop_front());
        mCount++;
        if (mAddr == DEPTH - 1) begin
          mFull = 1;
          mQ.delete();
        end else begin
          mAddr++;
        end
      end
    end else if (expReady && v) begin
      if (op > 11) begin
        mErr = 1;
      end else begin
        mQ.push_back(expWord(op, rs, rt, rd, imm, tgt));
`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
        if (op == 3 || op >= 9) mQ.push_back(32'h0);
`endif
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, rdy, 0);
  endtask

  task automatic doFlush();
    step(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1, 1);
  endtask

  initial begin
    logic [3:0]  rOp;
    logic [4:0]  rRs, rRt, rRd;
    logic [15:0] rImm;
    logic [25:0] rTgt;
    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_imm = 0; in_target = 0; flush = 0; imem_ready = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(0);
    chk("rst_addr", 32'(obsAddr), 32'h0);
    chk("rst_wdata", obsData, 32'h0);

    // add r3,r1,r2
    step(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 0);
    idle(1);
    chk("add_we", 32'(obsWe), 32'h1);
    chk("add_word", obsData, 32'h00221820);
    chk("add_addr", 32'(obsAddr), 32'h0);
    idle(1);
    chk("add_cnt", 32'(obsWords), 32'h1);

    // addi then lw
    doFlush();
    step(1, 4'd5, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1, 0);
    idle(1);
    chk("addi_word", obsData, 32'h20220005);
    step(1, 4'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1, 0);
    idle(1);
    chk("lw_word", obsData, 32'h8FA80004);
    chk("lw_addr", 32'(obsAddr), 32'h1);

    // jr held by imem_ready low
    doFlush();
    step(1, 4'd3, 5'd31, 5'd7, 5'd9, 16'hABCD, 26'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(i == 3);
      chk("jr_word", obsData, 32'h03E00008);
      chk("jr_we", 32'(obsWe), 32'h1);
      chk("jr_rdy", 32'(obsReady), 32'h0);
    end
`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
    idle(1);
`endif

    // illegal op
    doFlush();
    step(1, 4'd13, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1, 0);
    idle(1);
    chk("ill_err", 32'(obsErr), 32'h1);
    chk("ill_we", 32'(obsWe), 32'h0);
    chk("ill_cnt", 32'(obsWords), 32'h0);
    doFlush();
    idle(1);
    chk("ill_clr", 32'(obsErr), 32'h0);

    // fill memory with j
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1, 0);
      idle(1);
`ifndef MIPS_ENC_DELAY_SLOT_PAD_EN
      chk("j_word", obsData, 32'h08000010);
      chk("j_addr", 32'(obsAddr), 32'(i));
`endif
    end
    idle(1);
    idle(1);
    chk("fill_full", 32'(obsFull), 32'h1);
    chk("fill_rdy", 32'(obsReady), 32'h0);
    chk("fill_cnt", 32'(obsWords), 32'(DEPTH));
    doFlush();
    idle(1);
    chk("flush_addr", 32'(obsAddr), 32'h0);
    chk("flush_rdy", 32'(obsReady), 32'h1);

`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
    doFlush();
    step(1, 4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1, 0);
    idle(1);
    chk("beq_word", obsData, 32'h1022FFFF);
    idle(1);
    chk("pad_word", obsData, 32'h0);
    chk("pad_addr", 32'(obsAddr), 32'h1);
    idle(1);
    chk("pad_cnt", 32'(obsWords), 32'h2);
`endif

    // async reset during a pending write
    doFlush();
    step(1, 4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 0);
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we), 32'h0);
    chk("arst_addr", 32'(imem_addr), 32'h0);
    chk("arst_rdy", 32'(in_ready), 32'h1);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rOp  = 4'($urandom_range(0, 14));
      rRs  = 5'($urandom);
      rRt  = 5'($urandom);
      rRd  = 5'($urandom);
      rImm = 16'($urandom);
      rTgt = 26'($urandom);
      step($urandom_range(0, 9) < 6, rOp, rRs, rRt, rRd, rImm, rTgt,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
